// File: rtl/uart_pkg.sv
// Shared constants for the UART baud generator: default geometry and
// oversample divisors for a 50 MHz clock at 16x oversampling.
package uart_pkg;

    localparam int OVERSAMPLE_DEF = 16;
    localparam int DIV_W_DEF      = 16;

    localparam int DIV_9600   = 326;
    localparam int DIV_19200  = 163;
    localparam int DIV_57600  = 54;
    localparam int DIV_115200 = 27;

    typedef struct packed {
        logic os;
        logic mid;
        logic bitp;
    } ticks_t;

endpackage

// File: rtl/uart_tick_div.sv
// Generic modulo counter with enable and synchronous clear. wrap_o flags the
// clock edge on which the count returns from modulus-1 to 0.
module uart_tick_div #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clear_i,
    input  logic         en_i,
    input  logic [W-1:0] modulus_i,
    output logic [W-1:0] count_o,
    output logic         wrap_o
);

    logic [W-1:0] count_q, count_d;
    logic         at_last;

    always_comb begin
        at_last = (count_q == modulus_i - W'(1));
        wrap_o  = en_i && !clear_i && at_last;
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = at_last ? '0 : count_q + W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/uart_baud_gen.sv
// Loadable baud/oversample tick generator with phase resync and a bit-rate
// square wave. Define UART_BAUD_FRAC_EN to add a fractional divisor part.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE  = OVERSAMPLE_DEF,
    parameter int DIV_W       = DIV_W_DEF,
    parameter int DEFAULT_DIV = DIV_9600,
    parameter int FRAC_W      = 4
) (
    input  logic              clk_50m,
    input  logic              rst,
    input  logic              en,
    input  logic [DIV_W-1:0]  div_in,
    input  logic              div_load,
    input  logic              resync,
`ifdef UART_BAUD_FRAC_EN
    input  logic [FRAC_W-1:0] frac_in,
`endif
    output logic              os_tick,
    output logic              mid_tick,
    output logic              bit_tick,
    output logic              clk_out,
    output logic              div_err
);

    localparam int OS_W  = $clog2(OVERSAMPLE + 1);
    localparam int CNT_W = DIV_W + 1;

    if (OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0 || FRAC_W < 1) begin : g_bad_params
        $error("uart_baud_gen: OVERSAMPLE must be even and >= 4, FRAC_W must be >= 1");
    end

    logic [DIV_W-1:0] div_reg_q, div_reg_d;
    ticks_t           ticks_q, ticks_d;
    logic             clk_out_q, clk_out_d;
    logic             div_err_q, div_err_d;
    logic             load_ok;
    logic             clear;
    logic [CNT_W-1:0] cnt_mod;
    logic [CNT_W-1:0] cnt_unused;
    logic             cnt_wrap;
    logic [OS_W-1:0]  os_cnt;
    logic             os_wrap;

    // A divisor below 2 is rejected outright and leaves the running phase alone.
    assign load_ok = div_load && (div_in >= DIV_W'(2));
    assign clear   = load_ok || resync;

`ifdef UART_BAUD_FRAC_EN
    logic [FRAC_W-1:0] frac_reg_q, frac_reg_d;
    logic [FRAC_W-1:0] acc_q, acc_d;
    logic              stretch_q, stretch_d;

    // A carry out of the phase accumulator lengthens the following period by one clock.
    always_comb begin
        frac_reg_d = load_ok ? frac_in : frac_reg_q;
        acc_d      = acc_q;
        stretch_d  = stretch_q;
        if (clear) begin
            acc_d     = '0;
            stretch_d = 1'b0;
        end else if (cnt_wrap) begin
            {stretch_d, acc_d} = {1'b0, acc_q} + {1'b0, frac_reg_q};
        end
    end

    always_ff @(posedge clk_50m) begin
        if (rst) begin
            frac_reg_q <= '0;
            acc_q      <= '0;
            stretch_q  <= 1'b0;
        end else begin
            frac_reg_q <= frac_reg_d;
            acc_q      <= acc_d;
            stretch_q  <= stretch_d;
        end
    end

    assign cnt_mod = {1'b0, div_reg_q} + CNT_W'(stretch_q);
`else
    assign cnt_mod = {1'b0, div_reg_q};
`endif

    uart_tick_div #(.W(CNT_W)) u_cnt (
        .clk_i     (clk_50m),
        .rst_i     (rst),
        .clear_i   (clear),
        .en_i      (en),
        .modulus_i (cnt_mod),
        .count_o   (cnt_unused),
        .wrap_o    (cnt_wrap)
    );

    uart_tick_div #(.W(OS_W)) u_os_cnt (
        .clk_i     (clk_50m),
        .rst_i     (rst),
        .clear_i   (clear),
        .en_i      (cnt_wrap),
        .modulus_i (OS_W'(OVERSAMPLE)),
        .count_o   (os_cnt),
        .wrap_o    (os_wrap)
    );

    always_comb begin
        div_reg_d    = load_ok ? div_in : div_reg_q;
        ticks_d.os   = cnt_wrap;
        ticks_d.mid  = cnt_wrap && (os_cnt == OS_W'(OVERSAMPLE / 2 - 1));
        ticks_d.bitp = os_wrap;
        clk_out_d    = clk_out_q;
        if (clear) begin
            clk_out_d = 1'b0;
        end else if (ticks_d.mid || ticks_d.bitp) begin
            clk_out_d = ~clk_out_q;
        end
        div_err_d    = div_load && !load_ok;
    end

    always_ff @(posedge clk_50m) begin
        if (rst) begin
            div_reg_q <= DIV_W'(DEFAULT_DIV);
            ticks_q   <= '0;
            clk_out_q <= 1'b0;
            div_err_q <= 1'b0;
        end else begin
            div_reg_q <= div_reg_d;
            ticks_q   <= ticks_d;
            clk_out_q <= clk_out_d;
            div_err_q <= div_err_d;
        end
    end

    assign os_tick  = ticks_q.os;
    assign mid_tick = ticks_q.mid;
    assign bit_tick = ticks_q.bitp;
    assign clk_out  = clk_out_q;
    assign div_err  = div_err_q;

endmodule
